// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode
// constants, ALU/PC select codes and the control-vector struct.
// The JUMP state exists only when MULTICYCLE_CONTROL_JUMP_EN is defined.
package multicycle_control_pkg;

    // State encoding, also visible on state_o for debug.
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    localparam logic [3:0] S_JUMP     = 4'd11;
`endif
    localparam logic [3:0] S_TRAP     = 4'd12;

    // Supported opcodes (low six bits of the IR opcode field).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // alu_op codes: add, subtract (branch compare), decode from funct.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // pc_source codes: ALU result, ALUOut register, jump target.
    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;
`endif

    // alu_src_b codes: register B, constant 4, sign-extended imm, imm << 2.
    localparam logic [1:0] ALU_B_REG       = 2'b00;
    localparam logic [1:0] ALU_B_FOUR      = 2'b01;
    localparam logic [1:0] ALU_B_IMM       = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SHIFT = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // States that wait on mem_ready and are therefore guarded by the timer.
    function automatic logic is_mem_wait_state(input logic [3:0] st);
        return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;

    logic                pc_write;
    logic                pc_write_cond;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_source;
    logic                illegal_op;
    logic                mem_timeout;
    logic [3:0]          state_o;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_timeout, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_timeout, state_o
    );
endinterface

// File: rtl/multicycle_control_wait_timer.sv
// mc_wait_timer: counts cycles spent waiting on memory. expired flags the
// cycle whose wait would bring the count up to limit.
module mc_wait_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_en,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    // Widened compare so a limit of all-ones cannot wrap.
    assign expired = count_en &&
                     ((WIDTH+1)'(count) + (WIDTH+1)'(1) == (WIDTH+1)'(limit));

    // Wait counter: cleared on reset or state entry, advances while waiting.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle MIPS-style datapath.
// Optional build macro MULTICYCLE_CONTROL_JUMP_EN enables the JUMP state;
// without it opcode 000010 traps like any other unsupported opcode.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15   // legal range 1..255
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    logic [3:0] state;
    logic [3:0] state_next;
    logic [5:0] op;
    logic       op_upper_zero;
    logic       count_en;
    logic       timer_clear;
    logic       expired;
    logic       mem_timeout_q;
    ctrl_t      ctrl;

    assign op            = bus.opcode[5:0];
    assign op_upper_zero = ((bus.opcode >> 6) == '0);

    // Timer runs only while a memory state is stalled; any state entry
    // (including the FETCH retry after a timeout) restarts it from zero.
    assign count_en    = is_mem_wait_state(state) && !bus.mem_ready;
    assign timer_clear = (state_next != state) || expired;

    mc_wait_timer #(.WIDTH(8)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .count_en (count_en),
        .limit    (8'(MEM_TIMEOUT)),
        .expired  (expired)
    );

    // Next-state logic; mem_ready wins over an expiring timer.
    // NOTE: defaulting state_next before the case keeps this purely combinational.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready)  state_next = S_DECODE;
                else if (expired)   state_next = S_FETCH;
            end
            S_DECODE: begin
                if (!op_upper_zero) begin
                    state_next = S_TRAP;
                end else begin
                    case (op)
                        OP_RTYPE:     state_next = S_EXEC_R;
                        OP_LW, OP_SW: state_next = S_MEM_ADDR;
                        OP_BEQ:       state_next = S_BRANCH;
                        OP_ADDI:      state_next = S_EXEC_I;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
                        OP_J:         state_next = S_JUMP;
`endif
                        default:      state_next = S_TRAP;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                if (op == OP_SW)      state_next = S_MEM_WR;
                else if (op == OP_LW) state_next = S_MEM_RD;
                else                  state_next = S_FETCH;
            end
            S_MEM_RD: begin
                if (bus.mem_ready)  state_next = S_MEM_WB;
                else if (expired)   state_next = S_FETCH;
            end
            S_MEM_WR: begin
                if (bus.mem_ready || expired) state_next = S_FETCH;
            end
            S_EXEC_R: state_next = S_R_WB;
            S_EXEC_I: state_next = S_I_WB;
            default:  state_next = S_FETCH;
        endcase
    end

    // State register and registered timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            mem_timeout_q <= 1'b0;
        end else begin
            state         <= state_next;
            mem_timeout_q <= expired;
        end
    end

    // Moore output decode; reset forces every control low.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALU_B_IMM_SHIFT;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALU_B_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALU_OUT;
            end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
`endif
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
        if (rst) ctrl = '0;
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.mem_timeout   = mem_timeout_q && !rst;
    assign bus.state_o       = rst ? S_FETCH : state;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed steps followed by
// random instruction streams with random memory stalls, checked against a
// per-instruction phase model derived from the instruction-level behaviour.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_RD, P_MEM_WB, P_MEM_WR,
        P_EXEC_R, P_R_WB, P_EXEC_I, P_I_WB, P_BRANCH, P_JUMP, P_TRAP
    } phase_t;

    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic pending_to;
    logic [5:0] legal_ops [6];

    multicycle_control_if #(.OPCODE_W(6)) bus ();

    multicycle_control #(.OPCODE_W(6), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [16:0] obs_ctrl;
    assign obs_ctrl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                       bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                       bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                       bus.pc_source, bus.illegal_op};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] state_of(input phase_t p);
        case (p)
            P_FETCH:    return S_FETCH;
            P_DECODE:   return S_DECODE;
            P_MEM_ADDR: return S_MEM_ADDR;
            P_MEM_RD:   return S_MEM_RD;
            P_MEM_WB:   return S_MEM_WB;
            P_MEM_WR:   return S_MEM_WR;
            P_EXEC_R:   return S_EXEC_R;
            P_R_WB:     return S_R_WB;
            P_EXEC_I:   return S_EXEC_I;
            P_I_WB:     return S_I_WB;
            P_BRANCH:   return S_BRANCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            P_JUMP:     return S_JUMP;
`endif
            P_TRAP:     return S_TRAP;
            default:    return 4'hF;
        endcase
    endfunction

    // Expected control vector for a phase, written straight from the
    // per-state control table; anything not listed is 0.
    function automatic logic [16:0] exp_ctrl(input phase_t p, input logic mr);
        logic pw = 0, pwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] asb = 2'b00, aop = 2'b00, pcs = 2'b00;
        case (p)
            P_FETCH:    begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            P_DECODE:   begin asb = 2'b11; end
            P_MEM_ADDR: begin asa = 1; asb = 2'b10; end
            P_MEM_RD:   begin iord = 1; mrd = 1; end
            P_MEM_WB:   begin m2r = 1; rw = 1; end
            P_MEM_WR:   begin iord = 1; mwr = 1; end
            P_EXEC_R:   begin asa = 1; aop = 2'b10; end
            P_R_WB:     begin rdst = 1; rw = 1; end
            P_EXEC_I:   begin asa = 1; asb = 2'b10; end
            P_I_WB:     begin rw = 1; end
            P_BRANCH:   begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            P_JUMP:     begin pw = 1; pcs = 2'b10; end
            P_TRAP:     begin ill = 1; end
            default:    ;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
    endfunction

    // One clock: drive mem_ready, compare at the falling edge, advance.
    task automatic cyc(input phase_t p, input logic mr, input string tag);
        bus.mem_ready = mr;
        #4;
        check({tag, " state"}, 32'(bus.state_o), 32'(state_of(p)));
        check({tag, " ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl(p, mr)));
        check({tag, " mem_timeout"}, 32'(bus.mem_timeout), 32'(pending_to));
        pending_to = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Memory phase: ready stays low for 'waits' cycles. Reaching TIMEOUT
    // low cycles abandons the instruction; the pulse shows next cycle.
    task automatic mem_phase(input phase_t p, input int waits, input string tag,
                             output bit aborted);
        aborted = 1'b0;
        if (waits >= TIMEOUT) begin
            for (int k = 0; k < TIMEOUT; k++) cyc(p, 1'b0, tag);
            pending_to = 1'b1;
            aborted    = 1'b1;
        end else begin
            for (int k = 0; k < waits; k++) cyc(p, 1'b0, tag);
            cyc(p, 1'b1, tag);
        end
    endtask

    // Instruction-level model: the phase sequence each opcode walks through.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                             input string tag);
        phase_t seq[$];
        bit     ab;
        bus.opcode = op;
        mem_phase(P_FETCH, wf, tag, ab);
        if (ab) return;
        cyc(P_DECODE, 1'($urandom_range(0, 1)), tag);
        case (op)
            6'b000000: begin seq.push_back(P_EXEC_R); seq.push_back(P_R_WB); end
            6'b100011: begin seq.push_back(P_MEM_ADDR); seq.push_back(P_MEM_RD);
                             seq.push_back(P_MEM_WB); end
            6'b101011: begin seq.push_back(P_MEM_ADDR); seq.push_back(P_MEM_WR); end
            6'b000100: seq.push_back(P_BRANCH);
            6'b001000: begin seq.push_back(P_EXEC_I); seq.push_back(P_I_WB); end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            6'b000010: seq.push_back(P_JUMP);
`endif
            default:   seq.push_back(P_TRAP);
        endcase
        foreach (seq[i]) begin
            if (seq[i] == P_MEM_RD || seq[i] == P_MEM_WR) begin
                mem_phase(seq[i], wm, tag, ab);
                if (ab) return;
            end else begin
                cyc(seq[i], 1'($urandom_range(0, 1)), tag);
            end
        end
    endtask

    // Cycles from FETCH back to FETCH with memory always ready, seen on state_o.
    task automatic measure_latency(input logic [5:0] op, input int exp, input string tag);
        int n = 0;
        bus.opcode    = op;
        bus.mem_ready = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.state_o != S_FETCH && n < 20);
        check({tag, " latency"}, 32'(n), 32'(exp));
    endtask

    // Compare all outputs against their reset values while rst is high.
    task automatic check_reset(input string tag);
        #4;
        check({tag, " ctrl"}, 32'(obs_ctrl), 32'd0);
        check({tag, " mem_timeout"}, 32'(bus.mem_timeout), 32'd0);
        check({tag, " state"}, 32'(bus.state_o), 32'(S_FETCH));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wf, wm;
        logic [5:0] op;
        checks     = 0;
        failures   = 0;
        pending_to = 1'b0;
        legal_ops  = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

        // Reset state.
        rst           = 1'b1;
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check_reset("reset");
        rst = 1'b0;

        // Latency with memory always ready.
        measure_latency(6'b000000, 4, "lat_r");
        measure_latency(6'b100011, 5, "lat_lw");
        measure_latency(6'b101011, 4, "lat_sw");
        measure_latency(6'b000100, 3, "lat_beq");
        measure_latency(6'b001000, 4, "lat_addi");
        measure_latency(6'b111111, 3, "lat_trap");
        measure_latency(6'b000010, 3, "lat_j");

        // Exact control vectors per state, no stalls.
        run_instr(6'b000000, 0, 0, "r");
        run_instr(6'b100011, 0, 0, "lw");
        run_instr(6'b101011, 0, 0, "sw");
        run_instr(6'b000100, 0, 0, "beq");
        run_instr(6'b001000, 0, 0, "addi");
        run_instr(6'b111111, 0, 0, "illegal");
        run_instr(6'b000010, 0, 0, "jump");

        // Timeout boundaries.
        run_instr(6'b100011, 0, 15, "lw_timeout");
        run_instr(6'b100011, 0, 14, "lw_ready_at_15");
        run_instr(6'b101011, 0, 15, "sw_timeout");
        run_instr(6'b000000, 15, 0, "fetch_timeout");
        run_instr(6'b000000, 14, 0, "fetch_ready_at_15");

        // Reset held for three cycles in the middle of a stalled load.
        bus.opcode = 6'b100011;
        cyc(P_FETCH, 1'b1, "rst_mid");
        cyc(P_DECODE, 1'b1, "rst_mid");
        cyc(P_MEM_ADDR, 1'b1, "rst_mid");
        cyc(P_MEM_RD, 1'b0, "rst_mid");
        cyc(P_MEM_RD, 1'b0, "rst_mid");
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) check_reset("rst_hold");
        rst = 1'b0;
        run_instr(6'b100011, 0, 14, "after_rst");

        // Random instruction mix with random stalls.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                6:       op = 6'b111111;
                7:       op = 6'($urandom);
                default: op = legal_ops[$urandom_range(0, 5)];
            endcase
            wf = ($urandom_range(0, 9) == 0) ? 13 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 5) == 0) ? 13 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 3));
            run_instr(op, wf, wm, "rand");
        end
        cyc(P_FETCH, 1'b0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode width; bits above [5:0] SHALL be zero for a legal opcode.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum cycles waited for mem_ready in one memory state; range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 opcode  input  OPCODE_W  instruction opcode from IR, sampled in DECODE.
REQ-006 mem_ready  input  1  memory completed current read/write this cycle.
REQ-007 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-008 alu_src_b, alu_op, pc_source  output  2 each  datapath mux/ALU selects.
REQ-009 illegal_op  output  1  one-cycle pulse, unsupported opcode.
REQ-010 mem_timeout  output  1  one-cycle pulse, mem_ready not seen within MEM_TIMEOUT cycles.
REQ-011 state_o  output  4  current state encoding, debug.

Function
REQ-012 Moore FSM; all outputs SHALL decode from state register only (mem_ready gates pc_write/ir_write in FETCH only); outputs not listed for a state are 0.
REQ-013 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, TRAP.
REQ-014 FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; advance to DECODE when mem_ready=1, else hold.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; dispatch: 000000->EXEC_R, 100011/101011->MEM_ADDR, 000100->BRANCH, 001000->EXEC_I, 000010->JUMP, other->TRAP.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; ->MEM_RD for lw, MEM_WR for sw (opcode held stable by IR).
REQ-017 MEM_RD: iord=1, mem_read=1; ->MEM_WB on mem_ready. MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; ->FETCH.
REQ-018 MEM_WR: iord=1, mem_write=1; ->FETCH on mem_ready.
REQ-019 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; ->R_WB. R_WB: reg_dst=1, mem_to_reg=0, reg_write=1; ->FETCH.
REQ-020 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00; ->I_WB. I_WB: reg_dst=0, reg_write=1; ->FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH.
REQ-022 JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-023 TRAP: illegal_op=1, no write enables; ->FETCH.
REQ-024 Wait counter (8-bit) SHALL clear on entry to FETCH/MEM_RD/MEM_WR, increment each cycle mem_ready=0 there; reaching MEM_TIMEOUT SHALL pulse mem_timeout, drop the access, go to FETCH (from FETCH: retry, PC unchanged).
REQ-025 mem_ready=1 on the same cycle as timeout SHALL count as completion; no timeout pulse.
REQ-026 Latency with mem_ready always 1: R/addi/sw 4 cycles, lw 5, beq/j 3, trap 3.

Reset
REQ-027 rst=1 at a clock edge SHALL load FETCH and clear the wait counter, mid-instruction included; no partial write completes afterwards.
REQ-028 While rst=1 every control output, illegal_op and mem_timeout SHALL be 0; state_o shows FETCH.

Configuration
REQ-029 Macro MULTICYCLE_CONTROL_JUMP_EN defined: opcode 000010 dispatches to JUMP; undefined: JUMP state absent, 000010 ->TRAP, pc_source never 10.

Structure
REQ-030 Package multicycle_control_pkg SHALL hold state encoding, opcode constants, alu_op and pc_source constants.
REQ-031 Wait counter SHALL be sub-module mc_wait_timer (clear, count enable, limit, expired).

Verification
REQ-032 rst held 3 cycles mid-MEM_RD, then released -> state_o=FETCH, all write enables 0 during reset.
REQ-033 mem_ready=1 constant, opcodes 000000,100011,101011,000100,001000 -> 4,5,4,3,4 cycles each, exact control vectors per state.
REQ-034 opcode 111111 -> DECODE then TRAP with illegal_op=1 for 1 cycle, no reg_write/mem_write, back to FETCH.
REQ-035 lw with mem_ready low 15 cycles in MEM_RD -> mem_timeout pulse, reg_write never 1, next state FETCH; repeat with mem_ready=1 on cycle 15 -> MEM_WB, no pulse.
REQ-036 opcode 000010 with and without MULTICYCLE_CONTROL_JUMP_EN -> JUMP with pc_write=1, pc_source=10 vs TRAP with illegal_op=1.
